// File: rtl/pong_pkg.sv
// Shared Pong definitions: state codes for the text overlay and default match settings.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    OVER       = 3'd4,
    PAUSE      = 3'd5
  } state_e;

  localparam int unsigned WIN_SCORE_DEF   = 7;
  localparam int unsigned DELAY_TICKS_DEF = 120;

endpackage

// File: rtl/pong_delay_timer.sv
// Frame-tick down-counter: load restarts at DELAY_TICKS, stops at zero, timer_up flags zero.
module pong_delay_timer
  import pong_pkg::*;
#(
  parameter int unsigned DELAY_TICKS = DELAY_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic load,
  output logic timer_up
);

  localparam int unsigned W = $clog2(DELAY_TICKS + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = W'(DELAY_TICKS);
    else if (tick && count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign timer_up = (count_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve, scoring, win detection and delays.
// Optional pause state enabled by defining PONG_PAUSE_EN.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned DELAY_TICKS = DELAY_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] btn,
  input  logic       pause_btn,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       gra_still,
  output logic       ball_launch,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       winner
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       launch_q, launch_d;
  logic       btn_any_q;
  logic       press, timer_load, timer_up, timer_tick;

  assign press = (btn != '0) && !btn_any_q;

`ifdef PONG_PAUSE_EN
  logic pause_q, pause_edge;
  assign pause_edge = pause_btn && !pause_q;
  assign timer_tick = frame_tick && (state_q != PAUSE);
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign timer_tick   = frame_tick;
`endif

  pong_delay_timer #(.DELAY_TICKS(DELAY_TICKS)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (timer_tick),
    .load     (timer_load),
    .timer_up (timer_up)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b1;
      winner_q    <= 1'b0;
      launch_q    <= 1'b0;
      btn_any_q   <= 1'b0;
`ifdef PONG_PAUSE_EN
      pause_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      launch_q    <= launch_d;
      btn_any_q   <= (btn != '0);
`ifdef PONG_PAUSE_EN
      pause_q     <= pause_btn;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    launch_d    = 1'b0;
    timer_load  = 1'b0;
    case (state_q)
      IDLE: begin
        score_l_d = '0;
        score_r_d = '0;
        if (press) begin
          state_d     = SERVE_WAIT;
          serve_dir_d = 1'b1;
          timer_load  = 1'b1;
        end
      end
      SERVE_WAIT: begin
        if (timer_up && press) begin
          state_d  = PLAY;
          launch_d = 1'b1;
        end
      end
      PLAY: begin
        // A miss wins over a same-cycle pause edge so no point is lost.
        if (miss_l || miss_r) begin
          state_d    = POINT;
          timer_load = 1'b1;
          if (miss_l && !miss_r) begin
            if (score_r_q < WIN) score_r_d = score_r_q + 1'b1;
            serve_dir_d = 1'b0;
          end else if (miss_r && !miss_l) begin
            if (score_l_q < WIN) score_l_d = score_l_q + 1'b1;
            serve_dir_d = 1'b1;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (pause_edge) begin
          state_d = PAUSE;
        end
`endif
      end
      POINT: begin
        if (timer_up) begin
          timer_load = 1'b1;
          if (score_l_q == WIN || score_r_q == WIN) begin
            state_d  = OVER;
            winner_d = (score_r_q == WIN);
          end else begin
            state_d = SERVE_WAIT;
          end
        end
      end
      OVER: begin
        if (timer_up) begin
          state_d   = IDLE;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
`ifdef PONG_PAUSE_EN
      PAUSE: begin
        if (pause_edge) state_d = PLAY;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gra_still   = (state_q != PLAY);
    ball_launch = launch_q;
    serve_dir   = serve_dir_q;
    score_l     = score_l_q;
    score_r     = score_r_q;
    state       = state_q;
    winner      = winner_q;
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed-vector bench for pong_match_ctrl (WIN_SCORE=7, DELAY_TICKS=120).
module tb_pong_match_ctrl;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       reset, frame_tick, pause_btn, miss_l, miss_r;
  logic [3:0] btn;
  logic       gra_still, ball_launch, serve_dir, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  pong_match_ctrl #(.WIN_SCORE(7), .DELAY_TICKS(120)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .btn         (btn),
    .pause_btn   (pause_btn),
    .miss_l      (miss_l),
    .miss_r      (miss_r),
    .gra_still   (gra_still),
    .ball_launch (ball_launch),
    .serve_dir   (serve_dir),
    .score_l     (score_l),
    .score_r     (score_r),
    .state       (state),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    frame_tick = 1'b0;
  endtask

  task automatic press();
    btn = 4'b0001;
    step();
    btn = 4'b0000;
  endtask

  task automatic miss(input logic l, input logic r);
    miss_l = l;
    miss_r = r;
    step();
    miss_l = 1'b0;
    miss_r = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; btn = '0; pause_btn = 1'b0;
    miss_l = 1'b0; miss_r = 1'b0;
    step(); step();
    chk("rst_state", int'(state), int'(IDLE));
    chk("rst_score_l", int'(score_l), 0);
    chk("rst_score_r", int'(score_r), 0);
    chk("rst_serve_dir", int'(serve_dir), 1);
    chk("rst_gra_still", int'(gra_still), 1);
    chk("rst_launch", int'(ball_launch), 0);
    chk("rst_winner", int'(winner), 0);
    reset = 1'b0;
    step();

    press();
    chk("start_state", int'(state), int'(SERVE_WAIT));
    chk("start_serve_dir", int'(serve_dir), 1);
    chk("start_gra_still", int'(gra_still), 1);

    ticks(119);
    press();
    chk("early_press_state", int'(state), int'(SERVE_WAIT));
    chk("early_press_launch", int'(ball_launch), 0);
    ticks(1);
    press();
    chk("serve_state", int'(state), int'(PLAY));
    chk("serve_launch", int'(ball_launch), 1);
    chk("serve_gra_still", int'(gra_still), 0);
    step();
    chk("launch_one_cycle", int'(ball_launch), 0);

    miss(1'b0, 1'b1);
    chk("miss_r_score_l", int'(score_l), 1);
    chk("miss_r_score_r", int'(score_r), 0);
    chk("miss_r_serve_dir", int'(serve_dir), 1);
    chk("miss_r_state", int'(state), int'(POINT));
    chk("point_gra_still", int'(gra_still), 1);
    ticks(120);
    chk("point_hold", int'(state), int'(POINT));
    step();
    chk("point_to_serve", int'(state), int'(SERVE_WAIT));

    miss(1'b1, 1'b0);
    chk("miss_outside_play", int'(score_r), 0);
    chk("miss_outside_state", int'(state), int'(SERVE_WAIT));

    ticks(120);
    press();
    chk("play2_state", int'(state), int'(PLAY));
    miss(1'b1, 1'b1);
    chk("dbl_score_l", int'(score_l), 1);
    chk("dbl_score_r", int'(score_r), 0);
    chk("dbl_serve_dir", int'(serve_dir), 1);
    chk("dbl_state", int'(state), int'(POINT));
    ticks(121);

    for (int k = 0; k < 6; k++) begin
      ticks(120);
      press();
      miss(1'b1, 1'b0);
      ticks(121);
    end
    chk("pre_win_score_r", int'(score_r), 6);
    chk("pre_win_serve_dir", int'(serve_dir), 0);
    chk("pre_win_state", int'(state), int'(SERVE_WAIT));

    ticks(120);
    press();
    miss(1'b1, 1'b0);
    chk("win_score_r", int'(score_r), 7);
    chk("win_point_state", int'(state), int'(POINT));
    ticks(120);
    step();
    chk("over_state", int'(state), int'(OVER));
    chk("over_winner", int'(winner), 1);
    chk("over_score_r", int'(score_r), 7);
    chk("over_score_l", int'(score_l), 1);
    ticks(120);
    step();
    chk("idle_state", int'(state), int'(IDLE));
    chk("idle_score_l", int'(score_l), 0);
    chk("idle_score_r", int'(score_r), 0);

    press();
    ticks(120);
    press();
    chk("play3_state", int'(state), int'(PLAY));
    step();
    pause_btn = 1'b1;
    step();
`ifdef PONG_PAUSE_EN
    chk("pause_state", int'(state), int'(PAUSE));
    chk("pause_gra_still", int'(gra_still), 1);
    miss(1'b1, 1'b0);
    chk("pause_miss_ignored", int'(score_r), 0);
    chk("pause_hold", int'(state), int'(PAUSE));
    pause_btn = 1'b0;
    step();
    pause_btn = 1'b1;
    step();
    chk("resume_state", int'(state), int'(PLAY));
    chk("resume_no_launch", int'(ball_launch), 0);
`else
    chk("nopause_state", int'(state), int'(PLAY));
    chk("nopause_gra_still", int'(gra_still), 0);
`endif
    pause_btn = 1'b0;
    step();

    miss(1'b0, 1'b1);
    chk("mid_point_state", int'(state), int'(POINT));
    ticks(30);
    reset = 1'b1;
    step();
    chk("midrst_state", int'(state), int'(IDLE));
    chk("midrst_score_l", int'(score_l), 0);
    chk("midrst_serve_dir", int'(serve_dir), 1);
    chk("midrst_gra_still", int'(gra_still), 1);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
